// File: rtl/fetch_unit_if.sv
// Instruction-memory port of the fetch unit.
//
// Handshake: the master raises mem_req with mem_addr and keeps both stable
// until the slave returns mem_ack=1 for one cycle. mem_rdata is valid only in
// that ack cycle. After the ack cycle, mem_req drops for at least one cycle
// before the next request. An ack seen while mem_req is low has no effect.
interface fetch_unit_if #(
    parameter int ADDR_W = 8,
    parameter int IW_W   = 16
);
    logic [ADDR_W-1:0] mem_addr;
    logic              mem_req;
    logic              mem_ack;
    logic [IW_W-1:0]   mem_rdata;

    modport master (
        output mem_addr,
        output mem_req,
        input  mem_ack,
        input  mem_rdata
    );

    modport slave (
        input  mem_addr,
        input  mem_req,
        output mem_ack,
        output mem_rdata
    );
endinterface

// File: rtl/fetch_unit.sv
// Instruction fetch unit: holds the program counter and the instruction
// register. It runs a two-state fetch handshake with instruction memory.
// A fetched HALT opcode (top nibble 4'hF) freezes the unit until reset.
module fetch_unit #(
    parameter int ADDR_W = 8,
    parameter int IW_W   = 16
) (
    input  logic              clk,
    input  logic              reset,      // asynchronous, active low
    input  logic              LoadIR,
    input  logic              IncPC,
    input  logic              LoadPC,
    input  logic              SelPC,
    input  logic [ADDR_W-1:0] JumpReg,
    fetch_unit_if.master      mem,
    output logic [7:0]        Opcode,
    output logic [7:0]        Imm,
    output logic [ADDR_W-1:0] PC,
    output logic              ir_valid,
    output logic              fetch_busy,
    output logic              halted,
    output logic              overrun,
    output logic              state_dbg   // 0 = IDLE, 1 = REQ
);

    typedef enum logic {
        IDLE = 1'b0,
        REQ  = 1'b1
    } state_t;

    state_t          state;
    logic [IW_W-1:0] ir;
    logic [ADDR_W-1:0] pc_load_val;

    assign Opcode    = ir[15:8];
    assign Imm       = ir[7:0];
    assign state_dbg = (state == REQ);

    // Jump source: the immediate is zero-extended or truncated to the PC width.
    assign pc_load_val = SelPC ? ADDR_W'(Imm) : JumpReg;

    // Fetch FSM, instruction register and sticky status flags.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state        <= IDLE;
            ir           <= '0;
            mem.mem_addr <= '0;
            mem.mem_req  <= 1'b0;
            ir_valid     <= 1'b0;
            fetch_busy   <= 1'b0;
            halted       <= 1'b0;
            overrun      <= 1'b0;
        end else begin
            ir_valid <= 1'b0;
            case (state)
                IDLE: begin
                    // The request address is the PC before any PC update on
                    // this same edge.
                    if (LoadIR && !halted) begin
                        state        <= REQ;
                        mem.mem_addr <= PC;
                        mem.mem_req  <= 1'b1;
                        fetch_busy   <= 1'b1;
                    end
                end
                REQ: begin
                    // A second fetch request cannot be queued; flag it and
                    // let the outstanding fetch complete.
                    if (LoadIR) begin
                        overrun <= 1'b1;
                    end
                    if (mem.mem_ack) begin
                        state       <= IDLE;
                        ir          <= mem.mem_rdata;
                        mem.mem_req <= 1'b0;
                        fetch_busy  <= 1'b0;
                        ir_valid    <= 1'b1;
                        if (mem.mem_rdata[15:12] == 4'hF) begin
                            halted <= 1'b1;
                        end
                    end
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

    // Program counter: a load takes priority over an increment. The PC is
    // frozen once halted.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            PC <= '0;
        end else if (!halted) begin
            if (LoadPC) begin
                PC <= pc_load_val;
            end else if (IncPC) begin
                PC <= PC + ADDR_W'(1);
            end
        end
    end

endmodule

// File: tb/tb_fetch_unit.sv
// Directed testbench for fetch_unit.
module tb_fetch_unit;

    logic       clk;
    logic       reset;
    logic       LoadIR;
    logic       IncPC;
    logic       LoadPC;
    logic       SelPC;
    logic [7:0] JumpReg;
    logic [7:0] Opcode;
    logic [7:0] Imm;
    logic [7:0] PC;
    logic       ir_valid;
    logic       fetch_busy;
    logic       halted;
    logic       overrun;
    logic       state_dbg;

    int tests_run    = 0;
    int tests_failed = 0;

    fetch_unit_if #(.ADDR_W(8), .IW_W(16)) mem_if ();

    fetch_unit #(.ADDR_W(8), .IW_W(16)) dut (
        .clk        (clk),
        .reset      (reset),
        .LoadIR     (LoadIR),
        .IncPC      (IncPC),
        .LoadPC     (LoadPC),
        .SelPC      (SelPC),
        .JumpReg    (JumpReg),
        .mem        (mem_if),
        .Opcode     (Opcode),
        .Imm        (Imm),
        .PC         (PC),
        .ir_valid   (ir_valid),
        .fetch_busy (fetch_busy),
        .halted     (halted),
        .overrun    (overrun),
        .state_dbg  (state_dbg)
    );

    // Clock and reset
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Advance one rising edge and settle just after it.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_inputs();
        LoadIR           = 1'b0;
        IncPC            = 1'b0;
        LoadPC           = 1'b0;
        SelPC            = 1'b0;
        JumpReg          = 8'h00;
        mem_if.mem_ack   = 1'b0;
        mem_if.mem_rdata = 16'h0000;
    endtask

    task automatic test_reset();
        clear_inputs();
        reset = 1'b1;
        #1;
        reset = 1'b0;
        #1;
        tests_run++; if (PC !== 8'h00) begin tests_failed++; $display("FAIL reset_pc: got %h exp %h", PC, 8'h00); end
        tests_run++; if (Opcode !== 8'h00) begin tests_failed++; $display("FAIL reset_opcode: got %h exp %h", Opcode, 8'h00); end
        tests_run++; if (mem_if.mem_req !== 1'b0) begin tests_failed++; $display("FAIL reset_mem_req: got %b exp 0", mem_if.mem_req); end
        tests_run++; if (mem_if.mem_addr !== 8'h00) begin tests_failed++; $display("FAIL reset_mem_addr: got %h exp 00", mem_if.mem_addr); end
        tick();
        tick();
        tests_run++; if ({ir_valid, fetch_busy, halted, overrun, state_dbg} !== 5'b00000) begin
            tests_failed++; $display("FAIL reset_flags: got %b exp 00000", {ir_valid, fetch_busy, halted, overrun, state_dbg});
        end
        reset = 1'b1;
        tick();
        tests_run++; if ({mem_if.mem_req, state_dbg, PC} !== {2'b00, 8'h00}) begin
            tests_failed++; $display("FAIL reset_release_idle: got %b/%b/%h exp 0/0/00", mem_if.mem_req, state_dbg, PC);
        end
    endtask

    task automatic test_basic_fetch();
        LoadIR = 1'b1;
        tick();
        LoadIR = 1'b0;
        tests_run++; if ({mem_if.mem_req, fetch_busy, state_dbg} !== 3'b111) begin
            tests_failed++; $display("FAIL fetch_req_start: got %b exp 111", {mem_if.mem_req, fetch_busy, state_dbg});
        end
        tests_run++; if (mem_if.mem_addr !== 8'h00) begin tests_failed++; $display("FAIL fetch_addr: got %h exp 00", mem_if.mem_addr); end
        tests_run++; if (ir_valid !== 1'b0) begin tests_failed++; $display("FAIL fetch_early_valid: got %b exp 0", ir_valid); end
        mem_if.mem_ack   = 1'b1;
        mem_if.mem_rdata = 16'h4305;
        tick();
        mem_if.mem_ack   = 1'b0;
        mem_if.mem_rdata = 16'h0000;
        tests_run++; if (Opcode !== 8'h43) begin tests_failed++; $display("FAIL fetch_opcode: got %h exp 43", Opcode); end
        tests_run++; if (Imm !== 8'h05) begin tests_failed++; $display("FAIL fetch_imm: got %h exp 05", Imm); end
        tests_run++; if ({ir_valid, mem_if.mem_req, fetch_busy} !== 3'b100) begin
            tests_failed++; $display("FAIL fetch_done: got %b exp 100", {ir_valid, mem_if.mem_req, fetch_busy});
        end
        tick();
        tests_run++; if (ir_valid !== 1'b0) begin tests_failed++; $display("FAIL fetch_valid_pulse: got %b exp 0", ir_valid); end
        tests_run++; if (overrun !== 1'b0) begin tests_failed++; $display("FAIL fetch_no_overrun: got %b exp 0", overrun); end
    endtask

    task automatic test_wait_overrun();
        int busy_cycles;
        int valid_pulses;
        busy_cycles  = 0;
        valid_pulses = 0;
        LoadIR = 1'b1;
        tick();
        LoadIR = 1'b0;
        if (fetch_busy === 1'b1) busy_cycles++;
        for (int i = 0; i < 3; i++) begin
            // Junk on the data bus without ack must not be captured.
            mem_if.mem_rdata = 16'hEEEE;
            LoadIR = (i == 1);
            tick();
            LoadIR = 1'b0;
            if (fetch_busy === 1'b1) busy_cycles++;
            if (ir_valid === 1'b1) valid_pulses++;
            tests_run++; if ({mem_if.mem_req, mem_if.mem_addr} !== {1'b1, 8'h00}) begin
                tests_failed++; $display("FAIL wait_req_stable[%0d]: got %b/%h exp 1/00", i, mem_if.mem_req, mem_if.mem_addr);
            end
        end
        tests_run++; if (Opcode !== 8'h43) begin tests_failed++; $display("FAIL wait_ir_held: got %h exp 43", Opcode); end
        tests_run++; if (overrun !== 1'b1) begin tests_failed++; $display("FAIL wait_overrun: got %b exp 1", overrun); end
        mem_if.mem_ack   = 1'b1;
        mem_if.mem_rdata = 16'h1234;
        tick();
        if (ir_valid === 1'b1) valid_pulses++;
        tests_run++; if ({Opcode, Imm} !== 16'h1234) begin tests_failed++; $display("FAIL wait_capture: got %h exp 1234", {Opcode, Imm}); end
        // Ack held while idle must be ignored.
        mem_if.mem_rdata = 16'h5678;
        tick();
        if (ir_valid === 1'b1) valid_pulses++;
        mem_if.mem_ack   = 1'b0;
        mem_if.mem_rdata = 16'h0000;
        tick();
        if (ir_valid === 1'b1) valid_pulses++;
        tests_run++; if (busy_cycles !== 4) begin tests_failed++; $display("FAIL wait_busy_cycles: got %0d exp 4", busy_cycles); end
        tests_run++; if (valid_pulses !== 1) begin tests_failed++; $display("FAIL wait_single_capture: got %0d exp 1", valid_pulses); end
        tests_run++; if ({Opcode, Imm} !== 16'h1234) begin tests_failed++; $display("FAIL idle_ack_ignored: got %h exp 1234", {Opcode, Imm}); end
        tests_run++; if ({mem_if.mem_req, overrun} !== 2'b01) begin
            tests_failed++; $display("FAIL wait_end_state: got %b exp 01", {mem_if.mem_req, overrun});
        end
    endtask

    task automatic test_pc_update();
        // Put 0x2A in the immediate field.
        LoadIR = 1'b1;
        tick();
        LoadIR = 1'b0;
        mem_if.mem_ack   = 1'b1;
        mem_if.mem_rdata = 16'h012A;
        tick();
        mem_if.mem_ack = 1'b0;
        tests_run++; if (Imm !== 8'h2A) begin tests_failed++; $display("FAIL pc_setup_imm: got %h exp 2A", Imm); end
        LoadPC = 1'b1; SelPC = 1'b0; JumpReg = 8'hFF;
        tick();
        LoadPC = 1'b0;
        tests_run++; if (PC !== 8'hFF) begin tests_failed++; $display("FAIL pc_load_jumpreg: got %h exp FF", PC); end
        IncPC = 1'b1;
        tick();
        IncPC = 1'b0;
        tests_run++; if (PC !== 8'h00) begin tests_failed++; $display("FAIL pc_wrap: got %h exp 00", PC); end
        LoadPC = 1'b1; SelPC = 1'b1; JumpReg = 8'h77;
        tick();
        LoadPC = 1'b0;
        tests_run++; if (PC !== 8'h2A) begin tests_failed++; $display("FAIL pc_load_imm: got %h exp 2A", PC); end
        LoadPC = 1'b1; SelPC = 1'b0; JumpReg = 8'h11; IncPC = 1'b1;
        tick();
        LoadPC = 1'b0;
        tests_run++; if (PC !== 8'h11) begin tests_failed++; $display("FAIL pc_load_priority: got %h exp 11", PC); end
        tick();
        IncPC = 1'b0;
        tests_run++; if (PC !== 8'h12) begin tests_failed++; $display("FAIL pc_increment: got %h exp 12", PC); end
        tick();
        tests_run++; if (PC !== 8'h12) begin tests_failed++; $display("FAIL pc_hold: got %h exp 12", PC); end
    endtask

    task automatic test_back_to_back();
        // Fetch, load and increment together: fetch sees the old PC.
        LoadIR = 1'b1; LoadPC = 1'b1; SelPC = 1'b0; JumpReg = 8'h40; IncPC = 1'b1;
        tick();
        LoadIR = 1'b0; LoadPC = 1'b0;
        tests_run++; if (mem_if.mem_addr !== 8'h12) begin tests_failed++; $display("FAIL combo_addr: got %h exp 12", mem_if.mem_addr); end
        tests_run++; if (PC !== 8'h40) begin tests_failed++; $display("FAIL combo_pc: got %h exp 40", PC); end
        // PC moves during the fetch; the latched address does not.
        tick();
        IncPC = 1'b0;
        tests_run++; if ({PC, mem_if.mem_addr} !== 16'h4112) begin
            tests_failed++; $display("FAIL pc_during_req: got %h/%h exp 41/12", PC, mem_if.mem_addr);
        end
        mem_if.mem_ack   = 1'b1;
        mem_if.mem_rdata = 16'h0207;
        tick();
        mem_if.mem_ack = 1'b0;
        tests_run++; if ({Opcode, Imm, ir_valid, halted} !== {16'h0207, 2'b10}) begin
            tests_failed++; $display("FAIL combo_capture: got %h/%b/%b exp 0207/1/0", {Opcode, Imm}, ir_valid, halted);
        end
    endtask

    task automatic test_halt();
        LoadIR = 1'b1;
        tick();
        LoadIR = 1'b0;
        tests_run++; if (mem_if.mem_addr !== 8'h41) begin tests_failed++; $display("FAIL halt_fetch_addr: got %h exp 41", mem_if.mem_addr); end
        mem_if.mem_ack   = 1'b1;
        mem_if.mem_rdata = 16'hF000;
        tick();
        mem_if.mem_ack = 1'b0;
        tests_run++; if ({halted, Opcode} !== {1'b1, 8'hF0}) begin
            tests_failed++; $display("FAIL halt_set: got %b/%h exp 1/F0", halted, Opcode);
        end
        LoadIR = 1'b1; IncPC = 1'b1; LoadPC = 1'b1; SelPC = 1'b0; JumpReg = 8'h99;
        mem_if.mem_ack   = 1'b1;
        mem_if.mem_rdata = 16'h3333;
        for (int i = 0; i < 3; i++) begin
            tick();
            tests_run++; if ({mem_if.mem_req, fetch_busy, PC, Opcode, Imm} !== {2'b00, 8'h41, 16'hF000}) begin
                tests_failed++; $display("FAIL halt_frozen[%0d]: got %b%b/%h/%h exp 00/41/F000", i, mem_if.mem_req, fetch_busy, PC, {Opcode, Imm});
            end
        end
        clear_inputs();
        tick();
        tests_run++; if (halted !== 1'b1) begin tests_failed++; $display("FAIL halt_sticky: got %b exp 1", halted); end
    endtask

    task automatic test_reset_mid_fetch();
        #2;
        reset = 1'b0;
        #1;
        tests_run++; if ({halted, overrun, PC} !== {2'b00, 8'h00}) begin
            tests_failed++; $display("FAIL reset_clears_halt: got %b%b/%h exp 00/00", halted, overrun, PC);
        end
        tick();
        reset = 1'b1;
        LoadIR = 1'b1;
        tick();
        LoadIR = 1'b0;
        tests_run++; if ({mem_if.mem_req, state_dbg} !== 2'b11) begin
            tests_failed++; $display("FAIL midreset_req: got %b exp 11", {mem_if.mem_req, state_dbg});
        end
        #2;
        reset = 1'b0;
        #1;
        tests_run++; if ({mem_if.mem_req, fetch_busy, state_dbg} !== 3'b000) begin
            tests_failed++; $display("FAIL midreset_async_drop: got %b exp 000", {mem_if.mem_req, fetch_busy, state_dbg});
        end
        mem_if.mem_ack   = 1'b1;
        mem_if.mem_rdata = 16'hABCD;
        tick();
        tests_run++; if ({Opcode, Imm} !== 16'h0000) begin tests_failed++; $display("FAIL midreset_ir_zero: got %h exp 0000", {Opcode, Imm}); end
        reset = 1'b1;
        tick();
        tests_run++; if ({Opcode, Imm, ir_valid, mem_if.mem_req, state_dbg} !== {16'h0000, 3'b000}) begin
            tests_failed++; $display("FAIL midreset_late_ack: got %h/%b exp 0000/000", {Opcode, Imm}, {ir_valid, mem_if.mem_req, state_dbg});
        end
        clear_inputs();
    endtask

    initial begin
        test_reset();
        test_basic_fetch();
        test_wait_overrun();
        test_pc_update();
        test_back_to_back();
        test_halt();
        test_reset_mid_fetch();
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
